pmbus_arbiter: RTL

PMBUS_ARBITER -- requirements
Module: pmbus_arbiter

---
 rtl/pmbus_arbiter.sv | 239 +++++++++++++++++++++++
 1 files changed

// File: rtl/pmbus_arbiter.sv
// ---------------------------------------------------------------------------
// pmbus_arbiter
//
// Shares one PMBus read/write engine between three requesters. Requests are
// granted round-robin. The winner's command, write data and direction are
// latched and presented to the engine until it returns a completion pulse.
// A mandatory idle gap follows every transaction.
//
// Optional feature (compile-time macro):
//   ARB_TIMEOUT_EN  - adds a transaction watchdog. A transaction still
//                     outstanding after P_TIMEOUT cycles is aborted with
//                     O_done + O_err. Without it O_err is tied low.
//
// Parameters:
//   P_DEV_ADDR  PMBus target address driven on O_dev_addr
//   P_TIMEOUT   watchdog limit in clock cycles (must be >= 1)
//   P_GAP       idle cycles between transactions (must be >= 1)
//
// Ports:
//   I_CLK_4M      in   1   clock, rising edge
//   I_rst         in   1   synchronous active-high reset
//   I_req         in   3   per-requester request level
//   I_req_rd      in   3   per-requester direction, 1 = read
//   I_req_cmd     in  24   per-requester command, requester i on [8i+7:8i]
//   I_req_data    in  48   per-requester write data, requester i on [16i+15:16i]
//   O_gnt         out  3   one-hot grant, held for the whole transaction
//   O_done        out  3   one-cycle completion pulse to the granted requester
//   O_err         out  1   one-cycle pulse with O_done on watchdog abort
//   O_rdata       out 16   last successfully read data
//   O_recv_en     out  1   read engine enable
//   O_send_en     out  1   write engine enable
//   O_dev_addr    out  7   target device address
//   O_cmd_addr    out  8   latched PMBus command
//   O_write_data  out 16   latched write data
//   O_BYTE        out  2   data byte count for the latched command
//   I_done_pulse  in   1   engine completion pulse
//   I_read_data   in  16   engine read result
// ---------------------------------------------------------------------------
module pmbus_arbiter #(
    parameter logic [6:0]  P_DEV_ADDR = 7'h24,
    parameter logic [19:0] P_TIMEOUT  = 20'd400_000,
    parameter logic [15:0] P_GAP      = 16'd400
) (
    input  logic        I_CLK_4M,
    input  logic        I_rst,
    input  logic [2:0]  I_req,
    input  logic [2:0]  I_req_rd,
    input  logic [23:0] I_req_cmd,
    input  logic [47:0] I_req_data,
    output logic [2:0]  O_gnt,
    output logic [2:0]  O_done,
    output logic        O_err,
    output logic [15:0] O_rdata,
    output logic        O_recv_en,
    output logic        O_send_en,
    output logic [6:0]  O_dev_addr,
    output logic [7:0]  O_cmd_addr,
    output logic [15:0] O_write_data,
    output logic [1:0]  O_BYTE,
    input  logic        I_done_pulse,
    input  logic [15:0] I_read_data
);

    typedef enum logic [1:0] {
        ST_IDLE,
        ST_WAIT,
        ST_GAP
    } state_t;

    if (P_GAP == 16'd0 || P_TIMEOUT == 20'd0) begin : g_param_check
        $error("pmbus_arbiter: P_GAP and P_TIMEOUT must be non-zero");
    end

    state_t      state, state_nxt;
    logic [1:0]  last_win, last_win_nxt;
    logic [15:0] gap_cnt, gap_cnt_nxt;

    logic [2:0]  gnt_nxt;
    logic [2:0]  done_nxt;
    logic [15:0] rdata_nxt;
    logic        recv_nxt;
    logic        send_nxt;
    logic [7:0]  cmd_nxt;
    logic [15:0] wdata_nxt;
    logic [1:0]  byte_nxt;

    logic [1:0]  win;
    logic        win_vld;

`ifdef ARB_TIMEOUT_EN
    logic [19:0] wd_cnt, wd_cnt_nxt;
    logic        err_nxt;
`endif

    function automatic logic [1:0] byte_count(input logic [7:0] cmd);
        case (cmd)
            8'h8B, 8'h21, 8'hAD: byte_count = 2'd2;
            8'hD3, 8'h98:        byte_count = 2'd1;
            default:             byte_count = 2'd2;
        endcase
    endfunction

    // Round-robin: search starts one past the previous winner.
    always_comb begin
        int unsigned idx;
        idx     = 0;
        win     = '0;
        win_vld = 1'b0;
        for (int unsigned i = 1; i <= 3; i++) begin
            idx = (32'(last_win) + i) % 32'd3;
            if (!win_vld && I_req[idx[1:0]]) begin
                win_vld = 1'b1;
                win     = idx[1:0];
            end
        end
    end

    always_comb begin
        state_nxt    = state;
        last_win_nxt = last_win;
        gap_cnt_nxt  = gap_cnt;
        gnt_nxt      = O_gnt;
        done_nxt     = '0;
        rdata_nxt    = O_rdata;
        recv_nxt     = O_recv_en;
        send_nxt     = O_send_en;
        cmd_nxt      = O_cmd_addr;
        wdata_nxt    = O_write_data;
        byte_nxt     = O_BYTE;
`ifdef ARB_TIMEOUT_EN
        wd_cnt_nxt   = wd_cnt;
        err_nxt      = 1'b0;
`endif

        case (state)
            ST_IDLE: begin
                if (win_vld) begin
                    gnt_nxt      = 3'b001 << win;
                    cmd_nxt      = I_req_cmd[{win, 3'b000} +: 8];
                    wdata_nxt    = I_req_data[{win, 4'b0000} +: 16];
                    byte_nxt     = byte_count(I_req_cmd[{win, 3'b000} +: 8]);
                    recv_nxt     = I_req_rd[win];
                    send_nxt     = ~I_req_rd[win];
                    last_win_nxt = win;
`ifdef ARB_TIMEOUT_EN
                    wd_cnt_nxt   = '0;
`endif
                    state_nxt    = ST_WAIT;
                end
            end

            ST_WAIT: begin
                // Completion wins over a watchdog expiry on the same edge.
                if (I_done_pulse) begin
                    done_nxt    = O_gnt;
                    gnt_nxt     = '0;
                    recv_nxt    = 1'b0;
                    send_nxt    = 1'b0;
                    if (O_recv_en) begin
                        rdata_nxt = I_read_data;
                    end
                    gap_cnt_nxt = '0;
                    state_nxt   = ST_GAP;
                end
`ifdef ARB_TIMEOUT_EN
                else if (wd_cnt == P_TIMEOUT - 20'd1) begin
                    done_nxt    = O_gnt;
                    err_nxt     = 1'b1;
                    gnt_nxt     = '0;
                    recv_nxt    = 1'b0;
                    send_nxt    = 1'b0;
                    gap_cnt_nxt = '0;
                    state_nxt   = ST_GAP;
                end else begin
                    wd_cnt_nxt  = wd_cnt + 20'd1;
                end
`endif
            end

            ST_GAP: begin
                if (gap_cnt == P_GAP - 16'd1) begin
                    gap_cnt_nxt = '0;
                    state_nxt   = ST_IDLE;
                end else begin
                    gap_cnt_nxt = gap_cnt + 16'd1;
                end
            end

            default: begin
                state_nxt = ST_IDLE;
            end
        endcase
    end

    always_ff @(posedge I_CLK_4M) begin
        if (I_rst) begin
            state        <= ST_IDLE;
            last_win     <= 2'd2;
            gap_cnt      <= '0;
            O_gnt        <= '0;
            O_done       <= '0;
            O_rdata      <= '0;
            O_recv_en    <= 1'b0;
            O_send_en    <= 1'b0;
            O_dev_addr   <= '0;
            O_cmd_addr   <= '0;
            O_write_data <= '0;
            O_BYTE       <= '0;
        end else begin
            state        <= state_nxt;
            last_win     <= last_win_nxt;
            gap_cnt      <= gap_cnt_nxt;
            O_gnt        <= gnt_nxt;
            O_done       <= done_nxt;
            O_rdata      <= rdata_nxt;
            O_recv_en    <= recv_nxt;
            O_send_en    <= send_nxt;
            O_dev_addr   <= P_DEV_ADDR;
            O_cmd_addr   <= cmd_nxt;
            O_write_data <= wdata_nxt;
            O_BYTE       <= byte_nxt;
        end
    end

`ifdef ARB_TIMEOUT_EN
    always_ff @(posedge I_CLK_4M) begin
        if (I_rst) begin
            wd_cnt <= '0;
            O_err  <= 1'b0;
        end else begin
            wd_cnt <= wd_cnt_nxt;
            O_err  <= err_nxt;
        end
    end
`else
    assign O_err = 1'b0;
`endif

endmodule
